// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// and data access. One transaction is outstanding at a time. Data has priority,
// but a saturating streak counter forces a fetch grant after MAX_D_STREAK
// consecutive data grants while fetch waits. A kill discards an in-flight
// fetch response.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr/if_kill            fetch request, address, redirect kill
//   if_rvalid/if_rdata/if_stall       fetch completion pulse, data, stall
//   d_req/d_we/d_addr/d_wdata/d_be    data request fields
//   d_done/d_rdata/d_stall            data completion pulse, load data, stall
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be                  registered memory request
//   mem_ready/mem_rvalid/mem_rdata    memory accept and response
module mem_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_kill,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_done,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          owner_f;   // 1 = current transaction belongs to fetch
  logic          drop;
  logic [SW-1:0] streak;
  logic          f_elig;
  logic          grant_d;
  logic          grant_f;
  logic          resp_drop;

  // Stalls are combinational from the request and the registered done pulses.
  assign if_stall = if_req && !if_rvalid;
  assign d_stall  = d_req && !d_done;

  // Next-state and grant decision.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    f_elig    = if_req && !if_kill;
    // A kill arriving with the response also discards it.
    resp_drop = drop || (owner_f && if_kill);
    case (state)
      S_IDLE: begin
        if (d_req && !(f_elig && (streak == SW'(MAX_D_STREAK)))) begin
          grant_d = 1'b1;
        end else if (f_elig) begin
          grant_f = 1'b1;
        end
        if (grant_d || grant_f) state_nxt = S_ISSUE;
      end
      S_ISSUE: if (mem_ready)  state_nxt = S_WAIT;
      S_WAIT:  if (mem_rvalid) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Request latch, response capture, streak and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_f   <= 1'b0;
      drop      <= 1'b0;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            owner_f   <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            // Count only data grants that made fetch wait; saturate.
            if (!if_req)                             streak <= '0;
            else if (streak != SW'(MAX_D_STREAK))    streak <= streak + SW'(1);
          end else if (grant_f) begin
            owner_f   <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            streak    <= '0;
          end
        end
        S_ISSUE: if (mem_ready) mem_req <= 1'b0;
        S_WAIT: begin
          if (mem_rvalid) begin
            if (owner_f) begin
              if (!resp_drop) begin
                if_rdata  <= mem_rdata;
                if_rvalid <= 1'b1;
              end
            end else begin
              if (!mem_we) d_rdata <= mem_rdata;
              d_done <= 1'b1;
            end
          end
        end
        S_RESP: drop <= 1'b0;
        default: ;
      endcase
      if (owner_f && if_kill && ((state == S_ISSUE) || (state == S_WAIT))) drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [XLEN-1:0]   if_addr = '0;
  logic              if_kill = 1'b0;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;
  logic              if_stall;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [XLEN-1:0]   d_addr = '0;
  logic [XLEN-1:0]   d_wdata = '0;
  logic [XLEN/8-1:0] d_be = '0;
  logic              d_done;
  logic [XLEN-1:0]   d_rdata;
  logic              d_stall;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_ready = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [XLEN-1:0]   mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req = 1'b0; if_kill = 1'b0; d_req = 1'b0; d_we = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if ({mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin n_err++; $display("FAIL reset_mem_fields: got %h/%h/%h/%h want 0", mem_we, mem_addr, mem_wdata, mem_be); end
    n_cmp++; if ({if_rvalid, d_done} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b%b want 00", if_rvalid, d_done); end
    n_cmp++; if ({if_rdata, d_rdata} !== '0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0", if_rdata, d_rdata); end
    n_cmp++; if ({if_stall, d_stall} !== 2'b00) begin n_err++; $display("FAIL reset_stalls_idle: got %b%b want 00", if_stall, d_stall); end
    if_req = 1'b1; d_req = 1'b1;
    #1;
    n_cmp++; if ({if_stall, d_stall} !== 2'b11) begin n_err++; $display("FAIL reset_stalls_req: got %b%b want 11", if_stall, d_stall); end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch;
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0010; mem_ready = 1'b1;      // t
    #1;
    n_cmp++; if (if_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_t: got %b want 1", if_stall); end
    tick();                                                         // t+1
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_mem_addr: got %h we %b want 10 we 0", mem_addr, mem_we); end
    n_cmp++; if (if_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_t1: got %b want 1", if_stall); end
    tick();                                                         // t+2
    n_cmp++; if (mem_req !== 1'b0 || if_rvalid !== 1'b0 || if_stall !== 1'b1) begin n_err++; $display("FAIL fetch_wait: got req %b rv %b stall %b want 0 0 1", mem_req, if_rvalid, if_stall); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    tick();                                                         // t+3
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) begin n_err++; $display("FAIL fetch_done: got rv %b data %h want 1 13", if_rvalid, if_rdata); end
    n_cmp++; if (if_stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_done: got %b want 0", if_stall); end
    idle_inputs();
    tick();                                                         // t+4
    n_cmp++; if (if_rvalid !== 1'b0) begin n_err++; $display("FAIL fetch_pulse_len: got %b want 0", if_rvalid); end
  endtask

  task automatic test_store_delayed;
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    #1;
    n_cmp++; if (d_stall !== 1'b1) begin n_err++; $display("FAIL store_stall: got %b want 1", d_stall); end
    for (int i = 0; i < 3; i++) begin                               // t+1..t+3
      tick();
      n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {2'b11, 32'h80, 32'hDEAD_BEEF, 4'hF})
        begin n_err++; $display("FAIL store_issue_%0d: got req %b we %b a %h d %h be %h", i, mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
    end
    mem_ready = 1'b1;
    tick();                                                         // t+4
    mem_ready = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || d_done !== 1'b0) begin n_err++; $display("FAIL store_wait: got req %b done %b want 0 0", mem_req, d_done); end
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();                                                         // t+5
    n_cmp++; if (d_done !== 1'b1 || d_stall !== 1'b0) begin n_err++; $display("FAIL store_done: got done %b stall %b want 1 0", d_done, d_stall); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL store_rdata: got %h want 0", d_rdata); end
    idle_inputs();
    tick();
    n_cmp++; if (d_done !== 1'b0) begin n_err++; $display("FAIL store_pulse_len: got %b want 0", d_done); end
  endtask

  task automatic test_streak;
    logic got [10];
    logic pend;
    int   ng;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    pend = 1'b0; ng = 0;
    for (int i = 0; i < 10; i++) got[i] = 1'b0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      tick();
      mem_rvalid = pend; mem_rdata = 32'(c);
      pend = mem_req;
      if (mem_req) begin got[ng] = (mem_addr == 32'h100); ng++; end
    end
    n_cmp++; if (ng != 10) begin n_err++; $display("FAIL streak_timeout: got %0d grants want 10", ng); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (got[i] !== ((i == 4) || (i == 9))) begin n_err++; $display("FAIL streak_grant_%0d: got fetch=%b want %b", i, got[i], (i == 4) || (i == 9)); end
    end
    idle_inputs();
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_kill;
    do_reset();
    if_req = 1'b1; if_addr = 32'h20; mem_ready = 1'b1;
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick();
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hAAAA_0001) begin n_err++; $display("FAIL kill_preload: got rv %b data %h want 1 aaaa0001", if_rvalid, if_rdata); end
    if_req = 1'b0; mem_rvalid = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h40;                                // t
    tick(); tick();                                                 // t+2 WAIT
    if_kill = 1'b1; if_req = 1'b0;
    tick();                                                         // t+3
    if_kill = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    tick();                                                         // t+4
    mem_rvalid = 1'b0;
    n_cmp++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hAAAA_0001) begin n_err++; $display("FAIL kill_drop: got rv %b data %h want 0 aaaa0001", if_rvalid, if_rdata); end
    tick();                                                         // t+5 IDLE
    if_req = 1'b1; if_addr = 32'h60;
    n_cmp++; if (if_rvalid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL kill_idle: got rv %b req %b want 0 0", if_rvalid, mem_req); end
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h60) begin n_err++; $display("FAIL kill_regrant: got req %b a %h want 1 60", mem_req, mem_addr); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h5555;
    tick();
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h5555) begin n_err++; $display("FAIL kill_after: got rv %b data %h want 1 5555", if_rvalid, if_rdata); end
    if_req = 1'b0; mem_rvalid = 1'b0;
    tick();
    // Kill arriving in the same cycle as the response.
    if_req = 1'b1; if_addr = 32'h70;
    tick(); tick();
    if_kill = 1'b1; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h9999;
    tick();
    idle_inputs();
    n_cmp++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h5555) begin n_err++; $display("FAIL kill_same_cycle: got rv %b data %h want 0 5555", if_rvalid, if_rdata); end
    tick();
  endtask

  task automatic test_rst_mid;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF; mem_ready = 1'b1;
    tick(); tick();                                                 // WAIT
    rst = 1'b1; d_req = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_be, d_done, d_rdata} !== '0) begin n_err++; $display("FAIL rst_mid_clear: got req %b a %h done %b rd %h", mem_req, mem_addr, d_done, d_rdata); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if (d_done !== 1'b0 || d_rdata !== 32'h0 || mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_late: got done %b rd %h req %b want 0 0 0", d_done, d_rdata, mem_req); end
    d_req = 1'b1; d_addr = 32'h104;
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin n_err++; $display("FAIL rst_mid_next_req: got req %b a %h want 1 104", mem_req, mem_addr); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    n_cmp++; if (d_done !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rst_mid_next_done: got done %b rd %h want 1 cafef00d", d_done, d_rdata); end
    idle_inputs();
    tick();
  endtask

  task automatic test_both_same_cycle;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b1;
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_err++; $display("FAIL both_data_first: got req %b a %h want 1 200", mem_req, mem_addr); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h11;
    tick();
    n_cmp++; if (d_done !== 1'b1 || d_rdata !== 32'h11 || if_stall !== 1'b1) begin n_err++; $display("FAIL both_d_done: got done %b rd %h istall %b want 1 11 1", d_done, d_rdata, if_stall); end
    d_req = 1'b0; mem_rvalid = 1'b0;
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL both_idle: got req %b want 0", mem_req); end
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin n_err++; $display("FAIL both_fetch_next: got req %b a %h want 1 300", mem_req, mem_addr); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h22;
    tick();
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h22) begin n_err++; $display("FAIL both_f_done: got rv %b data %h want 1 22", if_rvalid, if_rdata); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_delayed();
    test_streak();
    test_kill();
    test_rst_mid();
    test_both_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
